mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, data word width in bits.
REQ-002 Parameter ADDR_W, default 16, byte address width in bits.
REQ-003 Parameter DEPTH, default 256, storage depth in words; power of two, at least 2.
REQ-004 Parameter LATENCY, default 4, cycles from request acceptance to Done; at least 1.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 Rd  in  1  read request.
REQ-008 Wr  in  1  write request.
REQ-009 Addr  in  ADDR_W  byte address; bit 0 must be 0.
REQ-010 DataIn  in  DATA_W  write data.
REQ-011 DataOut  out  DATA_W  read data; valid only while Done=1.
REQ-012 Stall  out  1  controller busy; requester holds its request and stage.
REQ-013 Done  out  1  one-cycle completion pulse.
REQ-014 err  out  1  one-cycle pulse flagging a rejected request.

Function
REQ-015 FSM states SHALL be: IDLE, BUSY, DONE.
REQ-016 A request is Rd XOR Wr with Addr[0]=0. It SHALL be accepted at the rising edge when the state is IDLE or DONE.
REQ-017 On acceptance, the block SHALL latch the operation type, word index Addr[log2(DEPTH):1] and DataIn. Higher address bits are ignored, so addresses wrap modulo 2*DEPTH bytes.
REQ-018 If LATENCY=1, acceptance SHALL go to DONE. Otherwise it SHALL go to BUSY, with a counter loaded to LATENCY-2.
REQ-019 In BUSY, the counter SHALL decrement each cycle. When it reaches 0, the next state SHALL be DONE. Done SHALL therefore be high exactly LATENCY cycles after the acceptance edge.
REQ-020 The write SHALL update storage on the edge entering DONE.
REQ-021 A read SHALL present the stored word on DataOut during DONE. Storage is sampled on the edge entering DONE.
REQ-022 In DONE, Done=1 for exactly one cycle. The next state SHALL be BUSY or DONE if a new request is accepted (back-to-back), else IDLE.
REQ-023 Stall SHALL be 1 exactly while the state is BUSY.
REQ-024 Rd, Wr, Addr and DataIn SHALL be ignored while in BUSY. No queuing.
REQ-025 A request with Rd=Wr=1, or with Addr[0]=1, presented in IDLE or DONE SHALL NOT be accepted. It SHALL cause err=1 in the following cycle, and the state SHALL go to IDLE.
REQ-026 When Done=0, DataOut SHALL be 0.
REQ-027 A read of a word written by the immediately preceding back-to-back write SHALL return the new data.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, counter 0, and latched fields 0. Stall, Done, err and DataOut SHALL be 0.
REQ-029 Reset SHALL clear all DEPTH storage words to 0.
REQ-030 Reset during BUSY SHALL abort the access: no write occurs and no Done is produced.
REQ-031 The first request SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding (2 bits) and the default parameter constants.
REQ-033 One sub-module, mem_lat_counter, SHALL implement the loadable down-counter with a zero flag, width clog2(LATENCY).
REQ-034 Storage SHALL be an internal register array of DEPTH x DATA_W.

Verification
REQ-035 Write then read, LATENCY=4: Wr at Addr 0x0010 with 0xBEEF, then Rd at 0x0010 → Stall high 3 cycles and Done in the 4th cycle, per access; read DataOut=0xBEEF.
REQ-036 LATENCY=1 back-to-back: Wr at 0x0002 with 0x1234 held across the Done cycle, then Rd at 0x0002 → Done on consecutive cycles; Stall never asserts; DataOut=0x1234.
REQ-037 Rejected requests: Rd at 0x0003 → err pulse one cycle later, no Done. Rd=Wr=1 → same.
REQ-038 Wrap-around, DEPTH=256: Wr at 0x0200 with 0xAAAA, then Rd at 0x0000 → DataOut=0xAAAA.
REQ-039 Reset mid-access: assert rst in the 2nd BUSY cycle of a Wr at 0x0004 with 0x5555 → outputs 0 at once; a later Rd at 0x0004 returns 0x0000.
REQ-040 Ignore while busy: change Addr and Wr during BUSY → the original access completes unchanged, and no extra Done follows.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller.
// Holds the 2-bit FSM state encoding, the default parameter values and a
// helper that sizes the latency down-counter.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 4;

    // Counter width is clog2(LATENCY), kept at a minimum of one bit so a
    // LATENCY of 1 still yields a legal vector.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response bus between a requester and mem_access_ctrl.
// Signals:
//   Rd, Wr   - read / write request (exactly one for a legal request)
//   Addr     - byte address, bit 0 must be 0
//   DataIn   - write data
//   DataOut  - read data, valid only while Done=1, otherwise 0
//   Stall    - controller busy
//   Done     - one-cycle completion pulse
//   err      - one-cycle pulse for a rejected request
// Modports: master = requester side, slave = controller side.
interface mem_access_ctrl_if
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              Rd;
    logic              Wr;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;
    logic              Stall;
    logic              Done;
    logic              err;

    modport master (
        output Rd, Wr, Addr, DataIn,
        input  DataOut, Stall, Done, err
    );

    modport slave (
        input  Rd, Wr, Addr, DataIn,
        output DataOut, Stall, Done, err
    );

endinterface

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a zero flag, used to time the BUSY phase.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears to 0)
//   load      - load load_val (takes priority over dec)
//   load_val  - value to load
//   dec       - decrement by one; holds at 0
//   zero      - count is 0
module mem_lat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller with fixed access latency.
// Accepts one read or write at a time, holds it for LATENCY cycles and then
// pulses Done. Writes land in storage on the edge entering DONE; reads sample
// storage on that same edge and present the word on DataOut during DONE.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset; clears FSM, latches and storage
//   bus  - mem_access_ctrl_if slave modport (request in, response out)
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic            clk,
    input  logic            rst,
    mem_access_ctrl_if.slave bus
);

    localparam int IDX_W    = $clog2(DEPTH);
    localparam int CNT_W    = cnt_width(LATENCY);
    localparam int LOAD_INT = (LATENCY > 1) ? (LATENCY - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_INT);

    state_t state_reg, state_next;

    logic              op_wr_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] data_out_reg, data_out_next;
    logic              err_reg, err_next;

    logic [IDX_W-1:0]  req_idx;
    logic              req_ok, req_bad, can_accept, accept, reject;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic              enter_done, acc_wr, mem_we;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_data;
    logic              unused_addr_hi;

    // Word index; bits above it are dropped so addresses wrap.
    assign req_idx        = bus.Addr[IDX_W:1];
    assign unused_addr_hi = ^bus.Addr[ADDR_W-1:IDX_W+1];

    assign req_ok     = (bus.Rd ^ bus.Wr) & ~bus.Addr[0];
    assign req_bad    = (bus.Rd | bus.Wr) & ~req_ok;
    assign can_accept = (state_reg != ST_BUSY);
    assign accept     = can_accept & req_ok;
    assign reject     = can_accept & req_bad;

    mem_lat_counter #(
        .WIDTH(CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    cnt_load   = 1'b1;
                    state_next = (LATENCY == 1) ? ST_DONE : ST_BUSY;
                end else begin
                    state_next = ST_IDLE;
                    err_next   = reject;
                end
            end
            ST_BUSY: begin
                if (cnt_zero) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The access completing on this edge comes from the latches when it has
    // been waiting in BUSY; with LATENCY=1 it is the request being accepted
    // on this very edge, so the live inputs are used instead.
    assign enter_done = (state_next == ST_DONE);
    assign acc_wr     = (state_reg == ST_BUSY) ? op_wr_reg : bus.Wr;
    assign acc_idx    = (state_reg == ST_BUSY) ? idx_reg   : req_idx;
    assign acc_data   = (state_reg == ST_BUSY) ? wdata_reg : bus.DataIn;
    assign mem_we     = enter_done & acc_wr;

    assign data_out_next = (enter_done && !acc_wr) ? mem_reg[acc_idx] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            op_wr_reg    <= 1'b0;
            idx_reg      <= '0;
            wdata_reg    <= '0;
            data_out_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            data_out_reg <= data_out_next;
            err_reg      <= err_next;
            if (accept) begin
                op_wr_reg <= bus.Wr;
                idx_reg   <= req_idx;
                wdata_reg <= bus.DataIn;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (mem_we) begin
            mem_reg[acc_idx] <= acc_data;
        end
    end

    assign bus.DataOut = data_out_reg;
    assign bus.Stall   = (state_reg == ST_BUSY);
    assign bus.Done    = (state_reg == ST_DONE);
    assign bus.err     = err_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench: one controller with LATENCY=4 and one with LATENCY=1.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DATA_W(16), .ADDR_W(16)) b4 ();
    mem_access_ctrl_if #(.DATA_W(16), .ADDR_W(16)) b1 ();

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr4();
        b4.Rd = 1'b0; b4.Wr = 1'b0; b4.Addr = '0; b4.DataIn = '0;
    endtask

    task automatic clr1();
        b1.Rd = 1'b0; b1.Wr = 1'b0; b1.Addr = '0; b1.DataIn = '0;
    endtask

    // Called just after a negedge. Drives a request to the LATENCY=4 unit,
    // checks Stall for 3 cycles then Done in the 4th. With noise set, a
    // different request is shown while busy and must be ignored. With chain
    // set, returns at the Done cycle so the next request is back-to-back.
    task automatic acc4(input string tag, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [15:0] din,
                        input logic [15:0] exp_dout, input bit noise, input bit chain);
        b4.Rd = rd; b4.Wr = wr; b4.Addr = addr; b4.DataIn = din;
        @(posedge clk); #1;
        if (noise) begin
            b4.Rd = 1'b1; b4.Wr = 1'b0; b4.Addr = addr + 16'h0002; b4.DataIn = ~din;
        end else begin
            clr4();
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) begin
                if (noise) clr4();
                chk({tag, "_stall_done"}, b4.Stall, 1'b0);
                chk({tag, "_done"}, b4.Done, 1'b1);
                chk({tag, "_dout"}, b4.DataOut, exp_dout);
            end else begin
                chk({tag, "_stall"}, b4.Stall, 1'b1);
                chk({tag, "_nodone"}, b4.Done, 1'b0);
            end
        end
        $display("txn %s rd=%0b wr=%0b addr=%h din=%h dout=%h", tag, rd, wr, addr, din, b4.DataOut);
        if (!chain) begin
            @(negedge clk);
            chk({tag, "_idle_done"}, b4.Done, 1'b0);
            chk({tag, "_idle_dout"}, b4.DataOut, 16'h0000);
        end
    endtask

    task automatic rej4(input string tag, input logic rd, input logic wr, input logic [15:0] addr);
        b4.Rd = rd; b4.Wr = wr; b4.Addr = addr; b4.DataIn = 16'hFFFF;
        @(posedge clk); #1;
        clr4();
        @(negedge clk);
        chk({tag, "_err"}, b4.err, 1'b1);
        chk({tag, "_done"}, b4.Done, 1'b0);
        chk({tag, "_stall"}, b4.Stall, 1'b0);
        @(negedge clk);
        chk({tag, "_err_off"}, b4.err, 1'b0);
        chk({tag, "_done_off"}, b4.Done, 1'b0);
        $display("txn %s rd=%0b wr=%0b addr=%h rejected", tag, rd, wr, addr);
    endtask

    initial begin
        clr4();
        clr1();
        repeat (2) @(negedge clk);
        chk("rst_stall4", b4.Stall, 1'b0);
        chk("rst_done4", b4.Done, 1'b0);
        chk("rst_err4", b4.err, 1'b0);
        chk("rst_dout4", b4.DataOut, 16'h0000);
        chk("rst_done1", b1.Done, 1'b0);
        chk("rst_err1", b1.err, 1'b0);
        $display("txn reset");
        rst = 1'b0;

        // Write then read, first request right after reset release
        acc4("wr_beef", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
        acc4("rd_beef", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0);

        // Address wrap: 0x0200 and 0x0000 share word 0
        acc4("wr_wrap", 1'b0, 1'b1, 16'h0200, 16'hAAAA, 16'h0000, 1'b0, 1'b0);
        acc4("rd_wrap", 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hAAAA, 1'b0, 1'b0);

        // Rejected requests
        rej4("rej_odd", 1'b1, 1'b0, 16'h0003);
        rej4("rej_both", 1'b1, 1'b1, 16'h0010);

        // Inputs changed while busy are ignored
        acc4("wr_noise", 1'b0, 1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b1, 1'b0);
        acc4("rd_noise_orig", 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 1'b0);
        acc4("rd_noise_alt", 1'b1, 1'b0, 16'h0022, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Back-to-back write then read of the same word
        acc4("wr_b2b", 1'b0, 1'b1, 16'h0030, 16'h7777, 16'h0000, 1'b0, 1'b1);
        acc4("rd_b2b", 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h7777, 1'b0, 1'b0);

        // Reset in the second BUSY cycle of a write
        b4.Wr = 1'b1; b4.Addr = 16'h0004; b4.DataIn = 16'h5555;
        @(posedge clk); #1;
        clr4();
        @(negedge clk);
        chk("mid_busy1", b4.Stall, 1'b1);
        @(negedge clk);
        chk("mid_busy2", b4.Stall, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", b4.Stall, 1'b0);
        chk("mid_rst_done", b4.Done, 1'b0);
        chk("mid_rst_err", b4.err, 1'b0);
        chk("mid_rst_dout", b4.DataOut, 16'h0000);
        $display("txn reset during busy");
        @(negedge clk);
        rst = 1'b0;
        acc4("rd_aborted", 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0, 1'b0);
        acc4("rd_cleared", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // LATENCY=1: write held across Done, then read, all back-to-back
        b1.Wr = 1'b1; b1.Addr = 16'h0002; b1.DataIn = 16'h1234;
        @(posedge clk); #1;
        @(negedge clk);
        chk("l1_wr_done", b1.Done, 1'b1);
        chk("l1_wr_stall", b1.Stall, 1'b0);
        chk("l1_wr_dout", b1.DataOut, 16'h0000);
        $display("txn l1_wr addr=0002 din=1234");
        @(negedge clk);
        chk("l1_wr2_done", b1.Done, 1'b1);
        chk("l1_wr2_stall", b1.Stall, 1'b0);
        $display("txn l1_wr_held addr=0002 din=1234");
        b1.Rd = 1'b1; b1.Wr = 1'b0;
        @(posedge clk); #1;
        clr1();
        @(negedge clk);
        chk("l1_rd_done", b1.Done, 1'b1);
        chk("l1_rd_stall", b1.Stall, 1'b0);
        chk("l1_rd_dout", b1.DataOut, 16'h1234);
        $display("txn l1_rd addr=0002 dout=%h", b1.DataOut);
        @(negedge clk);
        chk("l1_idle_done", b1.Done, 1'b0);
        chk("l1_idle_dout", b1.DataOut, 16'h0000);

        // LATENCY=1: illegal request presented in DONE -> err, back to IDLE
        b1.Rd = 1'b1; b1.Addr = 16'h0006;
        @(posedge clk); #1;
        b1.Wr = 1'b1;
        @(negedge clk);
        chk("l1_rej_pre_done", b1.Done, 1'b1);
        @(posedge clk); #1;
        clr1();
        @(negedge clk);
        chk("l1_rej_err", b1.err, 1'b1);
        chk("l1_rej_done", b1.Done, 1'b0);
        @(negedge clk);
        chk("l1_rej_err_off", b1.err, 1'b0);
        chk("l1_rej_done_off", b1.Done, 1'b0);
        $display("txn l1_rej rd=1 wr=1 addr=0006 rejected");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
